// File: rtl/vedic_mult_if.sv
// Operand/result handshake bundle for the pipelined Vedic multiplier.
// Both sides use valid/ready. A beat moves when valid && ready are high at
// a rising clock edge. The sender holds its payload stable while valid is
// high and ready is low.
interface vedic_mult_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               tsigned;
    logic [TAG_W-1:0]   in_tag;
    logic [2*WIDTH-1:0] c;
    logic [TAG_W-1:0]   out_tag;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    modport slave (
        input  in_valid, a, b, tsigned, in_tag, out_ready,
        output in_ready, c, out_tag, out_valid, busy
    );

    modport master (
        output in_valid, a, b, tsigned, in_tag, out_ready,
        input  in_ready, c, out_tag, out_valid, busy
    );
endinterface

// File: rtl/vedic_mult_pipe.sv
// Recursive Vedic (crosswise) unsigned multiplier cell, NxN -> 2N.
// The cell splits down to 2x2 leaves, which are built from plain gates.
module vedic_mult_cell #(
    parameter int N = 2
) (
    input  logic [N-1:0]   x_i,
    input  logic [N-1:0]   y_i,
    output logic [2*N-1:0] p_o
);
    generate
        if (N == 2) begin : g_leaf
            logic t_lo, t_hi, cross_c, top;
            assign t_lo    = x_i[1] & y_i[0];
            assign t_hi    = x_i[0] & y_i[1];
            assign cross_c = t_lo & t_hi;
            assign top     = x_i[1] & y_i[1];
            assign p_o[0]  = x_i[0] & y_i[0];
            assign p_o[1]  = t_lo ^ t_hi;
            assign p_o[2]  = top ^ cross_c;
            assign p_o[3]  = top & cross_c;
        end else begin : g_split
            localparam int H = N / 2;
            logic [N-1:0] ll, lh, hl, hh;
            vedic_mult_cell #(.N(H)) u_ll (.x_i(x_i[H-1:0]), .y_i(y_i[H-1:0]), .p_o(ll));
            vedic_mult_cell #(.N(H)) u_lh (.x_i(x_i[H-1:0]), .y_i(y_i[N-1:H]), .p_o(lh));
            vedic_mult_cell #(.N(H)) u_hl (.x_i(x_i[N-1:H]), .y_i(y_i[H-1:0]), .p_o(hl));
            vedic_mult_cell #(.N(H)) u_hh (.x_i(x_i[N-1:H]), .y_i(y_i[N-1:H]), .p_o(hh));
            // Vertical + crosswise terms. The exact product always fits in 2N bits.
            assign p_o = {{N{1'b0}}, ll}
                       + ({{N{1'b0}}, lh} << H)
                       + ({{N{1'b0}}, hl} << H)
                       + {hh, {N{1'b0}}};
        end
    endgenerate
endmodule

// Three-stage signed/unsigned Vedic multiplier with a tag sideband.
// S1 holds magnitudes and sign flags. S2 holds four half-width partial products.
// S3 holds the sign-corrected sum. The whole pipe stalls together on back-pressure.
module vedic_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    vedic_mult_if.slave bus,
    output logic        dbg_carry_o
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    generate
        if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
            $error("vedic_mult_pipe: WIDTH must be 4, 8, 16 or 32");
        end
    endgenerate

    logic adv;

    logic             v1_q, sa1_q, sb1_q;
    logic [WIDTH-1:0] ma1_q, mb1_q;
    logic [TAG_W-1:0] tag1_q;
    logic             sa_d, sb_d;
    logic [WIDTH-1:0] ma_d, mb_d;

    logic             v2_q, neg2_q;
    logic [WIDTH-1:0] ll2_q, lh2_q, hl2_q, hh2_q;
    logic [TAG_W-1:0] tag2_q;
    logic [WIDTH-1:0] ll_d, lh_d, hl_d, hh_d;

    logic             v3_q;
    logic [PW-1:0]    c3_q;
    logic [TAG_W-1:0] tag3_q;
    logic [PW:0]      sum_ext;
    logic [PW-1:0]    c3_d;

    // A full output slot blocks every stage. Empty slots (bubbles) are not squeezed out.
    assign adv          = !v3_q || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = v3_q;
    assign bus.c        = c3_q;
    assign bus.out_tag  = tag3_q;
    assign bus.busy     = v1_q | v2_q | v3_q;

    // S1 prep: sign flags and magnitudes. The most negative value maps to 2^(WIDTH-1).
    always_comb begin
        sa_d = bus.tsigned & bus.a[WIDTH-1];
        sb_d = bus.tsigned & bus.b[WIDTH-1];
        ma_d = sa_d ? (~bus.a + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.a;
        mb_d = sb_d ? (~bus.b + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.b;
    end

    // S1 register: capture an operation on each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            sa1_q  <= 1'b0;
            sb1_q  <= 1'b0;
            ma1_q  <= '0;
            mb1_q  <= '0;
            tag1_q <= '0;
        end else if (adv) begin
            v1_q   <= bus.in_valid;
            sa1_q  <= sa_d;
            sb1_q  <= sb_d;
            ma1_q  <= ma_d;
            mb1_q  <= mb_d;
            tag1_q <= bus.in_tag;
        end
    end

    vedic_mult_cell #(.N(H)) u_pp_ll (.x_i(ma1_q[H-1:0]),     .y_i(mb1_q[H-1:0]),     .p_o(ll_d));
    vedic_mult_cell #(.N(H)) u_pp_lh (.x_i(ma1_q[H-1:0]),     .y_i(mb1_q[WIDTH-1:H]), .p_o(lh_d));
    vedic_mult_cell #(.N(H)) u_pp_hl (.x_i(ma1_q[WIDTH-1:H]), .y_i(mb1_q[H-1:0]),     .p_o(hl_d));
    vedic_mult_cell #(.N(H)) u_pp_hh (.x_i(ma1_q[WIDTH-1:H]), .y_i(mb1_q[WIDTH-1:H]), .p_o(hh_d));

    // S2 register: four partial products plus the result sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q   <= 1'b0;
            neg2_q <= 1'b0;
            ll2_q  <= '0;
            lh2_q  <= '0;
            hl2_q  <= '0;
            hh2_q  <= '0;
            tag2_q <= '0;
        end else if (adv) begin
            v2_q   <= v1_q;
            neg2_q <= sa1_q ^ sb1_q;
            ll2_q  <= ll_d;
            lh2_q  <= lh_d;
            hl2_q  <= hl_d;
            hh2_q  <= hh_d;
            tag2_q <= tag1_q;
        end
    end

    // S3 combine: the sum uses one spare bit so that the carry can be observed. Then the sign is applied.
    always_comb begin
        sum_ext = {{(WIDTH+1){1'b0}}, ll2_q}
                + ({{(WIDTH+1){1'b0}}, lh2_q} << H)
                + ({{(WIDTH+1){1'b0}}, hl2_q} << H)
                + ({{(WIDTH+1){1'b0}}, hh2_q} << WIDTH);
        c3_d = neg2_q ? (~sum_ext[PW-1:0] + {{(PW-1){1'b0}}, 1'b1}) : sum_ext[PW-1:0];
    end

    assign dbg_carry_o = sum_ext[PW];

    // S3 register: the visible result, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q   <= 1'b0;
            c3_q   <= '0;
            tag3_q <= '0;
        end else if (adv) begin
            v3_q   <= v2_q;
            c3_q   <= c3_d;
            tag3_q <= tag2_q;
        end
    end
endmodule
